// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
package ctrl_pkg;

  // Main sequencer states; state_o exposes this encoding for debug.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  // ALU operation codes understood by the datapath ALU.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  // Instruction classes the sequencer cares about.
  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_class_t;

  // Immediate generator formats.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Next-PC source select.
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Register write-back source select.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Map funct3 (and funct7[5]) of an R/I ALU instruction onto an ALU op.
  // funct7[5] picks SUB only for register-register adds, SRA for both forms.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                               input logic       funct7_5,
                                               input logic       is_reg);
    alu_op_t op;
    case (funct3)
      3'b000:  op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register: class, ALU op,
// immediate format, operand selects and legality.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output alu_op_t      alu_op,
  output logic [2:0]   imm_fmt,
  output logic         alu_src,
  output logic         alu_a_pc,
  output logic         legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  // Register numbers and immediate bits belong to the datapath, not to us.
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify the opcode and derive operand/ALU controls; rejected funct3 codes fall to illegal.
  always_comb begin
    cls      = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    imm_fmt  = IMM_I;
    alu_src  = 1'b1;
    alu_a_pc = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls     = CLS_ALU_R;
        alu_op  = alu_from_funct3(funct3, funct7_5, 1'b1);
        alu_src = 1'b0;
      end
      OPC_OP_IMM: begin
        cls    = CLS_ALU_I;
        alu_op = alu_from_funct3(funct3, funct7_5, 1'b0);
      end
      OPC_LOAD: begin
        if (!(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) begin
          cls = CLS_LOAD;
        end
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        if (funct3 <= 3'b010) begin
          cls = CLS_STORE;
        end
      end
      OPC_BRANCH: begin
        alu_op  = ALU_SUB;
        alu_src = 1'b0;
        imm_fmt = IMM_B;
        if (!(funct3 == 3'b010 || funct3 == 3'b011)) begin
          cls = CLS_BRANCH;
        end
      end
      OPC_LUI: begin
        cls     = CLS_LUI;
        alu_op  = ALU_PASSB;
        imm_fmt = IMM_U;
      end
      OPC_AUIPC: begin
        cls      = CLS_AUIPC;
        imm_fmt  = IMM_U;
        alu_a_pc = 1'b1;
      end
      OPC_JAL: begin
        cls     = CLS_JAL;
        imm_fmt = IMM_J;
      end
      OPC_JALR: begin
        cls = CLS_JALR;
      end
      default: begin
        cls = CLS_ILLEGAL;
      end
    endcase
  end

  assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Walks each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared datapath and
// stalls on the single memory port's req/ack handshake.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ADDRESS_WIDTH-1:0] instr_i,
  input  logic                     eq_i,
  input  logic                     lt_i,
  input  logic                     ltu_i,
  input  logic                     mem_ack_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic                     mem_addr_sel_o,
  output logic                     ir_write_o,
  output logic                     pc_write_o,
  output logic [1:0]               PCsrc_o,
  output logic                     regWrite_en_o,
  output logic [1:0]               result_sel_o,
  output logic [3:0]               ALUctrl_o,
  output logic                     ALUsrc_o,
  output logic                     alu_a_sel_o,
  output logic [2:0]               IMMctrl_o,
  output logic [2:0]               state_o,
  output logic                     illegal_o
);

  state_t       state_reg;
  state_t       state_next;
  instr_class_t cls;
  alu_op_t      alu_op;
  logic [2:0]   imm_fmt;
  logic         alu_src;
  logic         alu_a_pc;
  logic         legal;
  logic         branch_taken;
  logic         alu_ctrl_live;

  instr_decode u_decode (
    .instr    (instr_i[31:0]),
    .cls      (cls),
    .alu_op   (alu_op),
    .imm_fmt  (imm_fmt),
    .alu_src  (alu_src),
    .alu_a_pc (alu_a_pc),
    .legal    (legal)
  );

  // Branch condition from the ALU flags, selected by funct3.
  always_comb begin
    branch_taken = 1'b0;
    case (instr_i[14:12])
      3'b000:  branch_taken = eq_i;
      3'b001:  branch_taken = !eq_i;
      3'b100:  branch_taken = lt_i;
      3'b101:  branch_taken = !lt_i;
      3'b110:  branch_taken = ltu_i;
      3'b111:  branch_taken = !ltu_i;
      default: branch_taken = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ALU/immediate controls follow the instruction register once it is loaded;
  // they stay quiet while fetching and after a trap.
  assign alu_ctrl_live = (state_reg == ST_DECODE)  || (state_reg == ST_EXECUTE) ||
                         (state_reg == ST_MEMORY)  || (state_reg == ST_WRITEBACK);
  assign ALUctrl_o   = alu_ctrl_live ? alu_op   : ALU_ADD;
  assign ALUsrc_o    = alu_ctrl_live ? alu_src  : 1'b0;
  assign alu_a_sel_o = alu_ctrl_live ? alu_a_pc : 1'b0;
  assign IMMctrl_o   = alu_ctrl_live ? imm_fmt  : IMM_I;
  assign state_o     = state_reg;

  // Next-state and per-state datapath enables; every instruction ends with exactly one pc_write.
  always_comb begin
    state_next     = state_reg;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    PCsrc_o        = PC_PLUS4;
    regWrite_en_o  = 1'b0;
    result_sel_o   = RES_ALU;
    illegal_o      = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_write_o = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = legal ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        if (cls == CLS_BRANCH) begin
          pc_write_o = 1'b1;
          PCsrc_o    = branch_taken ? PC_IMM : PC_PLUS4;
          state_next = ST_FETCH;
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_next = ST_MEMORY;
        end else begin
          state_next = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (cls == CLS_STORE);
        if (mem_ack_i) begin
          if (cls == CLS_STORE) begin
            pc_write_o = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        regWrite_en_o = 1'b1;
        pc_write_o    = 1'b1;
        state_next    = ST_FETCH;
        if (cls == CLS_LOAD) begin
          result_sel_o = RES_MEM;
        end else if (cls == CLS_JAL || cls == CLS_JALR) begin
          result_sel_o = RES_PC4;
        end
        if (cls == CLS_JAL) begin
          PCsrc_o = PC_IMM;
        end else if (cls == CLS_JALR) begin
          PCsrc_o = PC_ALU;
        end
      end
      ST_TRAP: begin
        illegal_o = 1'b1;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

endmodule
